// File: rtl/lsu.sv
// lsu: load/store unit sitting after the ALU.
// Takes the ALU result as the effective address and performs one data-memory
// access per memory instruction over a req/gnt/rvalid bus. Stores are lane
// replicated with byte enables; loads are shifted and sign/zero-extended.
// The core is stalled until the access completes, then done pulses once.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   req_valid            current instruction is a load/store
//   is_store             1=store, 0=load
//   funct3               RV32I width/sign (B, H, W, BU, HU)
//   addr, store_data     effective address and rs2 value
//   load_data            extended load result, valid with done
//   done, fault          one-cycle completion pulse, fault flag with done
//   stall                core holds PC and inputs while high
//   mem_req/mem_we       bus request and write enable
//   mem_addr             word-aligned bus address
//   mem_wdata/mem_be     lane-replicated write data, byte enables
//   mem_gnt              request accepted this cycle
//   mem_rvalid/mem_rdata read data return
module lsu #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  input  logic            is_store,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] store_data,
  output logic [XLEN-1:0] load_data,
  output logic            done,
  output logic            stall,
  output logic            fault,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic [3:0]      mem_be,
  input  logic            mem_gnt,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_DONE
  } state_t;

  state_t state, state_next;

  logic [1:0]      addr_lo;
  logic [2:0]      funct3_q;
  logic            fault_q;

  logic            bad_funct3;
  logic            misaligned;
  logic            illegal;
  logic [3:0]      be_calc;
  logic [XLEN-1:0] wdata_calc;
  logic [XLEN-1:0] shifted;
  logic [XLEN-1:0] ext;

  // Legality check on the incoming request
  always_comb begin
    bad_funct3 = is_store ? (funct3 > 3'b010)
                          : (funct3 == 3'b011 || funct3[2:1] == 2'b11);
    misaligned = (funct3[1:0] == 2'b01 && addr[0]) ||
                 (funct3 == 3'b010 && addr[1:0] != 2'b00);
    illegal    = bad_funct3 | misaligned;
  end

  // Byte enables and lane-replicated write data for the incoming request
  always_comb begin
    be_calc    = 4'b1111;
    wdata_calc = store_data;
    if (is_store) begin
      case (funct3[1:0])
        2'b00: begin
          be_calc    = 4'b0001 << addr[1:0];
          wdata_calc = {4{store_data[7:0]}};
        end
        2'b01: begin
          be_calc    = 4'b0011 << addr[1:0];
          wdata_calc = {2{store_data[15:0]}};
        end
        default: begin
          be_calc    = 4'b1111;
          wdata_calc = store_data;
        end
      endcase
    end
  end

  // Load alignment and extension from the registered access attributes
  always_comb begin
    shifted = mem_rdata >> {addr_lo, 3'b000};
    case (funct3_q)
      3'b000:  ext = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
      3'b001:  ext = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
      3'b100:  ext = {{(XLEN-8){1'b0}}, shifted[7:0]};
      3'b101:  ext = {{(XLEN-16){1'b0}}, shifted[15:0]};
      default: ext = shifted;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    stall      = 1'b0;
    done       = 1'b0;
    fault      = 1'b0;
    mem_req    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req_valid) begin
          stall      = 1'b1;
          state_next = illegal ? ST_DONE : ST_REQ;
        end
      end
      ST_REQ: begin
        stall   = 1'b1;
        mem_req = 1'b1;
        if (mem_gnt) state_next = mem_we ? ST_DONE : ST_WAIT;
      end
      ST_WAIT: begin
        stall = 1'b1;
        if (mem_rvalid) state_next = ST_DONE;
      end
      ST_DONE: begin
        done       = 1'b1;
        fault      = fault_q;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Bus attributes are captured at acceptance so they stay stable in REQ
  // regardless of what the core drives afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_lo   <= '0;
      funct3_q  <= '0;
      fault_q   <= 1'b0;
      load_data <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            addr_lo  <= addr[1:0];
            funct3_q <= funct3;
            fault_q  <= illegal;
            if (illegal) begin
              load_data <= '0;
            end else begin
              mem_we    <= is_store;
              mem_addr  <= {addr[XLEN-1:2], 2'b00};
              mem_be    <= be_calc;
              mem_wdata <= wdata_calc;
            end
          end
        end
        ST_REQ: begin
          if (mem_gnt && mem_we) load_data <= '0;
        end
        ST_WAIT: begin
          if (mem_rvalid) load_data <= ext;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu.sv
// tb_lsu: directed self-checking bench for lsu.
module tb_lsu;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        is_store;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic [31:0] load_data;
  logic        done;
  logic        stall;
  logic        fault;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  int errors = 0;
  int checks = 0;

  // Per-operation observations filled by run_op
  int          r_lat;
  logic        r_req_seen, r_stable, r_stall_ok, r_fault, r_we;
  logic [31:0] r_ld, r_addr, r_wdata;
  logic [3:0]  r_be;

  lsu #(.XLEN(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .is_store   (is_store),
    .funct3     (funct3),
    .addr       (addr),
    .store_data (store_data),
    .load_data  (load_data),
    .done       (done),
    .stall      (stall),
    .fault      (fault),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_be     (mem_be),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one access from IDLE and plays the bus slave: gnt after gnt_wait
  // refused request cycles, rvalid one cycle after a load grant.
  task automatic run_op(input string tag, input logic st, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] sd,
                        input logic [31:0] rd, input int gnt_wait);
    int   n_req;
    logic pend_rv;
    logic got_done;
    n_req = 0; pend_rv = 1'b0; got_done = 1'b0;
    r_lat = 0; r_req_seen = 1'b0; r_stable = 1'b1; r_stall_ok = 1'b1;
    r_fault = 1'b0; r_ld = '0; r_we = 1'b0; r_addr = '0; r_wdata = '0; r_be = '0;
    req_valid = 1'b1; is_store = st; funct3 = f3; addr = a; store_data = sd;
    for (int cyc = 1; cyc <= 40 && !got_done; cyc++) begin
      mem_rvalid = pend_rv;
      mem_rdata  = pend_rv ? rd : 32'h5A5A_5A5A;
      pend_rv    = 1'b0;
      mem_gnt    = 1'b0;
      #1;
      if (done) begin
        got_done = 1'b1;
        r_lat    = cyc;
        r_fault  = fault;
        r_ld     = load_data;
        if (stall) r_stall_ok = 1'b0;
      end else begin
        if (!stall) r_stall_ok = 1'b0;
        if (mem_req) begin
          if (!r_req_seen) begin
            r_req_seen = 1'b1;
            r_we = mem_we; r_addr = mem_addr; r_wdata = mem_wdata; r_be = mem_be;
          end else if (mem_we !== r_we || mem_addr !== r_addr ||
                       mem_wdata !== r_wdata || mem_be !== r_be) begin
            r_stable = 1'b0;
          end
          n_req++;
          mem_gnt = (n_req > gnt_wait);
          if (mem_gnt && !st) pend_rv = 1'b1;
        end
        tick();
      end
    end
    if (!got_done) check({tag, " timeout"}, 32'd0, 32'd1);
    req_valid = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
    tick();
    check({tag, " done_pulse"}, {31'd0, done}, 32'd0);
  endtask

  task automatic expect_op(input string tag, input int lat, input logic flt,
                           input logic [31:0] ld, input logic reqd);
    check({tag, " latency"},   r_lat, lat);
    check({tag, " fault"},     {31'd0, r_fault}, {31'd0, flt});
    check({tag, " load_data"}, r_ld, ld);
    check({tag, " req_seen"},  {31'd0, r_req_seen}, {31'd0, reqd});
    check({tag, " stall"},     {31'd0, r_stall_ok}, 32'd1);
  endtask

  task automatic expect_bus(input string tag, input logic we, input logic [31:0] ma,
                            input logic [3:0] be, input logic [31:0] wd);
    check({tag, " mem_we"},    {31'd0, r_we}, {31'd0, we});
    check({tag, " mem_addr"},  r_addr, ma);
    check({tag, " mem_be"},    {28'd0, r_be}, {28'd0, be});
    if (we) check({tag, " mem_wdata"}, r_wdata, wd);
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; is_store = 1'b0; funct3 = '0;
    addr = '0; store_data = '0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;

    #12;
    check("rst load_data", load_data, 32'd0);
    check("rst done",      {31'd0, done},    32'd0);
    check("rst fault",     {31'd0, fault},   32'd0);
    check("rst stall",     {31'd0, stall},   32'd0);
    check("rst mem_req",   {31'd0, mem_req}, 32'd0);
    check("rst mem_we",    {31'd0, mem_we},  32'd0);
    check("rst mem_addr",  mem_addr,  32'd0);
    check("rst mem_wdata", mem_wdata, 32'd0);
    check("rst mem_be",    {28'd0, mem_be}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    tick();

    run_op("lw", 1'b0, 3'b010, 32'h100, 32'h0, 32'hDEAD_BEEF, 0);
    expect_op("lw", 4, 1'b0, 32'hDEAD_BEEF, 1'b1);
    expect_bus("lw", 1'b0, 32'h100, 4'b1111, 32'h0);
    check("lw hold", load_data, 32'hDEAD_BEEF);

    run_op("lb", 1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF_0000, 0);
    expect_op("lb", 4, 1'b0, 32'hFFFF_FF80, 1'b1);
    expect_bus("lb", 1'b0, 32'h100, 4'b1111, 32'h0);

    run_op("lbu", 1'b0, 3'b100, 32'h103, 32'h0, 32'h80FF_0000, 0);
    expect_op("lbu", 4, 1'b0, 32'h0000_0080, 1'b1);

    run_op("lb_pos", 1'b0, 3'b000, 32'h101, 32'h0, 32'h0000_7F00, 0);
    expect_op("lb_pos", 4, 1'b0, 32'h0000_007F, 1'b1);

    run_op("lh", 1'b0, 3'b001, 32'h102, 32'h0, 32'h8001_1234, 0);
    expect_op("lh", 4, 1'b0, 32'hFFFF_8001, 1'b1);

    run_op("lhu", 1'b0, 3'b101, 32'h102, 32'h0, 32'h8001_1234, 0);
    expect_op("lhu", 4, 1'b0, 32'h0000_8001, 1'b1);

    run_op("lw_mis", 1'b0, 3'b010, 32'h101, 32'h0, 32'h0, 0);
    expect_op("lw_mis", 2, 1'b1, 32'h0, 1'b0);

    run_op("lh_mis", 1'b0, 3'b001, 32'h103, 32'h0, 32'h0, 0);
    expect_op("lh_mis", 2, 1'b1, 32'h0, 1'b0);

    run_op("ld_f3", 1'b0, 3'b110, 32'h100, 32'h0, 32'h0, 0);
    expect_op("ld_f3", 2, 1'b1, 32'h0, 1'b0);

    run_op("sh", 1'b1, 3'b001, 32'h202, 32'h1234_ABCD, 32'h0, 0);
    expect_op("sh", 3, 1'b0, 32'h0, 1'b1);
    expect_bus("sh", 1'b1, 32'h200, 4'b1100, 32'hABCD_ABCD);

    run_op("sb", 1'b1, 3'b000, 32'h101, 32'h0000_00AB, 32'h0, 0);
    expect_op("sb", 3, 1'b0, 32'h0, 1'b1);
    expect_bus("sb", 1'b1, 32'h100, 4'b0010, 32'hABAB_ABAB);

    run_op("st_f3", 1'b1, 3'b011, 32'h200, 32'h1111_2222, 32'h0, 0);
    expect_op("st_f3", 2, 1'b1, 32'h0, 1'b0);

    run_op("sw_wait", 1'b1, 3'b010, 32'h300, 32'hCAFE_F00D, 32'h0, 5);
    expect_op("sw_wait", 8, 1'b0, 32'h0, 1'b1);
    expect_bus("sw_wait", 1'b1, 32'h300, 4'b1111, 32'hCAFE_F00D);
    check("sw_wait stable", {31'd0, r_stable}, 32'd1);

    // Load a non-zero value, then reset while waiting for rvalid
    run_op("lw2", 1'b0, 3'b010, 32'h400, 32'h0, 32'h1357_9BDF, 0);
    expect_op("lw2", 4, 1'b0, 32'h1357_9BDF, 1'b1);
    req_valid = 1'b1; is_store = 1'b0; funct3 = 3'b010; addr = 32'h100; mem_gnt = 1'b1;
    tick();
    tick();
    req_valid = 1'b0; mem_gnt = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst mem_req",   {31'd0, mem_req}, 32'd0);
    check("mid_rst stall",     {31'd0, stall},   32'd0);
    check("mid_rst load_data", load_data, 32'd0);
    check("mid_rst mem_addr",  mem_addr,  32'd0);
    check("mid_rst mem_be",    {28'd0, mem_be}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    mem_rvalid = 1'b1; mem_rdata = 32'h1111_1111;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("late_rv done",      {31'd0, done},  32'd0);
      check("late_rv stall",     {31'd0, stall}, 32'd0);
      check("late_rv load_data", load_data, 32'd0);
    end
    mem_rvalid = 1'b0;
    tick();

    run_op("post_rst", 1'b0, 3'b100, 32'h102, 32'h0, 32'h00C3_0000, 0);
    expect_op("post_rst", 4, 1'b0, 32'h0000_00C3, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lsu.md
Name: lsu

Overview:
- Load/store unit downstream of the ALU. It takes the ALU result as the effective address and performs one data-memory access per memory instruction over a req/gnt/rvalid bus.
- It aligns and merges byte/halfword stores and sign/zero-extends loads.
- It holds the core in stall until the access completes, then pulses done for one cycle so the core retires the instruction and advances the PC.

Parameters:
- XLEN, 32, data and address width; only 32 is supported.

Ports:
- clk  in  1  core clock; all state updates on its rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  current instruction is a load/store; held high by core while stall=1
- is_store  in  1  1=store, 0=load
- funct3  in  3  RV32I width/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- addr  in  32  effective address (ALU result)
- store_data  in  32  rs2 value
- load_data  out  32  extended load result; valid when done=1
- done  out  1  one-cycle completion pulse
- stall  out  1  core must hold PC and inputs
- fault  out  1  one-cycle pulse with done: misaligned address or illegal funct3
- mem_req  out  1  bus request
- mem_we  out  1  write enable
- mem_addr  out  32  word-aligned address, addr[1:0] forced to 00
- mem_wdata  out  32  lane-shifted store data
- mem_be  out  4  byte enables
- mem_gnt  in  1  request accepted this cycle
- mem_rvalid  in  1  read data valid; earliest one cycle after gnt
- mem_rdata  in  32  read word

Behaviour:
- Reset state is IDLE. load_data=0, done=0, fault=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_be=0. All internal registers are 0.
- FSM states are IDLE, REQ, WAIT and DONE.
- IDLE, req_valid=0: stay in IDLE; stall=0.
- IDLE, req_valid=1:
  - stall=1 combinationally.
  - Register addr, funct3, is_store and store_data.
  - If the access is illegal, go to DONE with fault latched.
  - Otherwise go to REQ.
- Illegal access:
  - Illegal funct3: load with 011/110/111, or store with funct3>010.
  - Misaligned address: H/HU with addr[0]=1, or W with addr[1:0]!=00.
  - No bus request is issued for an illegal access.
- REQ:
  - Assert mem_req=1 with registered mem_we, mem_addr, mem_be and mem_wdata; hold all of them stable until gnt.
  - gnt=1 and store: go to DONE.
  - gnt=1 and load: go to WAIT.
  - gnt=0: stay in REQ; there is no timeout.
- WAIT:
  - mem_req=0.
  - On mem_rvalid=1: capture mem_rdata, shift right by 8*addr[1:0], extend per funct3 into load_data, go to DONE.
- DONE:
  - done=1, stall=0, fault=registered fault flag.
  - Unconditionally return to IDLE next cycle; the core has advanced, so req_valid in the next cycle belongs to a new instruction.
- Byte enables:
  - B: 0001 << addr[1:0].
  - H: 0011 << addr[1:0].
  - W: 1111.
  - Loads drive mem_be=1111.
- Store data:
  - B: mem_wdata = {4{sd[7:0]}}.
  - H: mem_wdata = {2{sd[15:0]}}.
  - W: mem_wdata = sd.
- Load extension: B sign-extends bit 7, H sign-extends bit 15, BU/HU zero-extend, W passes through.
- load_data holds its value until the next load completes. On a store or a fault completion it is 0.
- Latency (cycles from req_valid rise to done, inclusive):
  - Store with immediate gnt: 3 (IDLE, REQ, DONE).
  - Load with immediate gnt and rvalid one cycle later: 4.
  - Fault: 2.
- req_valid dropping while in REQ or WAIT is ignored; the transaction completes and done still pulses.
- mem_rvalid outside WAIT is ignored, as is mem_gnt outside REQ.
- Reset asserted mid-transaction: immediate return to IDLE; outputs take reset values asynchronously. A late rvalid after reset is ignored.

Test Plan:
- LW at addr=0x100 with mem_rdata=0xDEADBEEF, gnt immediate, rvalid next cycle -> mem_addr=0x100, mem_be=1111, done on cycle 4, load_data=0xDEADBEEF, fault=0.
- LB at addr=0x103 with rdata=0x80FF_0000 -> load_data=0xFFFFFF80. Same access as LBU -> load_data=0x00000080.
- SH at addr=0x202 with store_data=0x1234ABCD -> mem_addr=0x200, mem_be=1100, mem_wdata=0xABCDABCD, mem_we=1, done 3 cycles after req.
- LW at addr=0x101 -> no mem_req ever asserted, done=1 and fault=1 on cycle 2, load_data=0. Store with funct3=011 -> same fault response.
- SW with gnt held low 5 cycles -> mem_req, mem_addr, mem_be and mem_wdata stable all 5 cycles, stall=1 throughout, a single done pulse after gnt.
- LW issued, rst_n pulled low while in WAIT, later rvalid=1 after reset release -> all outputs 0, no done pulse, FSM in IDLE.
